// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The master side (pipeline/bench) drives hazard/branch/memory status and
// receives freeze, flush, status and performance-counter outputs.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             hazard;
   logic             branch_taken;
   logic             mem_access;
   logic             mem_ready;
   logic             perf_clr;
   logic             freeze_if;
   logic             freeze_id;
   logic             freeze_exe;
   logic             freeze_mem;
   logic             bubble_wb;
   logic             flush_id;
   logic             flush_exe;
   logic             mem_timeout_err;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] mem_wait_cycles;

   modport master (
      output hazard, branch_taken, mem_access, mem_ready, perf_clr,
      input  freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_wb,
             flush_id, flush_exe, mem_timeout_err, state,
             stall_cycles, flush_count, mem_wait_cycles
   );

   modport slave (
      input  hazard, branch_taken, mem_access, mem_ready, perf_clr,
      output freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_wb,
             flush_id, flush_exe, mem_timeout_err, state,
             stall_cycles, flush_count, mem_wait_cycles
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
// Freeze/flush controls are combinational from the FSM state and the current
// hazard/branch/memory inputs; the FSM holds the pipeline during multi-cycle
// memory accesses and latches a sticky error when the watchdog expires.
// Optional feature macro: PIPELINE_CTRL_PERF_CNT_EN (saturating perf counters).
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 8,
   parameter int CNT_W       = 32
) (
   input logic              clk,
   input logic              rst_n,
   pipeline_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

   state_t          state_q, state_d;
   logic [TO_W-1:0] wait_q, wait_d;
   logic            err_q, err_d;

   logic mem_stall;
   logic rule_err, rule_mem, rule_br, rule_hz;

   // State, wait counter and sticky error register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic and prioritised freeze/flush decode
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      err_d     = err_q;
      mem_stall = bus.mem_access & ~bus.mem_ready;

      // A stalled MEM stage owns the pipeline; branch and hazard wait behind it
      rule_err = (state_q == S_ERR);
      rule_mem = ~rule_err & mem_stall;
      rule_br  = ~rule_err & ~mem_stall & bus.branch_taken;
      rule_hz  = ~rule_err & ~mem_stall & ~bus.branch_taken & bus.hazard;

      case (state_q)
         S_RUN: begin
            if (mem_stall) begin
               state_d = S_WAIT;
               wait_d  = TO_W'(1);
            end
         end
         S_WAIT: begin
            if (!mem_stall) begin
               state_d = S_RUN;
               wait_d  = '0;
            end else if ((MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_CNT)) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (wait_q != '1) begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_RUN;
            wait_d  = '0;
         end
      endcase

      bus.freeze_if  = rule_err | rule_mem | rule_hz;
      bus.freeze_id  = rule_err | rule_mem | rule_hz;
      bus.freeze_exe = rule_err | rule_mem;
      bus.freeze_mem = rule_err | rule_mem;
      bus.bubble_wb  = rule_err | rule_mem;
      bus.flush_id   = rule_br;
      bus.flush_exe  = rule_br | rule_hz;
   end

   assign bus.state           = state_q;
   assign bus.mem_timeout_err = err_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q, memw_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      if (en && (v != '1)) return v + CNT_W'(1);
      return v;
   endfunction

   // Saturating event counters; a clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst_n || bus.perf_clr) begin
         stall_q <= '0;
         flush_q <= '0;
         memw_q  <= '0;
      end else begin
         stall_q <= sat_inc(stall_q, rule_hz);
         flush_q <= sat_inc(flush_q, rule_br);
         memw_q  <= sat_inc(memw_q, rule_mem);
      end
   end

   assign bus.stall_cycles    = stall_q;
   assign bus.flush_count     = flush_q;
   assign bus.mem_wait_cycles = memw_q;
`else
   assign bus.stall_cycles    = '0;
   assign bus.flush_count     = '0;
   assign bus.mem_wait_cycles = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Combines the hazard-detector output, the EXE-stage branch decision and the data-memory handshake into per-stage freeze and flush controls.
- Runs a small FSM that holds the pipeline through multi-cycle memory accesses, with a watchdog timeout.
- Optionally keeps saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before error; 0 disables the watchdog.
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- hazard  in  1  combinational RAW hazard from the hazard detector.
- branch_taken  in  1  EXE-stage branch/B taken.
- mem_access  in  1  MEM stage holds a load or store (r_en|w_en).
- mem_ready  in  1  data memory/SRAM controller completes this cycle.
- perf_clr  in  1  synchronous clear of perf counters.
- freeze_if  out  1  hold PC register.
- freeze_id  out  1  hold IF/ID register.
- freeze_exe  out  1  hold ID/EXE register.
- freeze_mem  out  1  hold EXE/MEM register.
- bubble_wb  out  1  MEM/WB loads a NOP (wb_en=0).
- flush_id  out  1  clear IF/ID register.
- flush_exe  out  1  clear ID/EXE register (bubble).
- mem_timeout_err  out  1  sticky watchdog error.
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR.
- stall_cycles  out  CNT_W  hazard-stall cycles (PERF_CNT_EN only).
- flush_count  out  CNT_W  branch flushes (PERF_CNT_EN only).
- mem_wait_cycles  out  CNT_W  memory-stall cycles (PERF_CNT_EN only).

Behaviour:
- Reset (rst_n=0 at edge): state=RUN, wait_cnt=0, mem_timeout_err=0, counters=0.
- All freeze/flush outputs are combinational from state and inputs. They are 0 whenever state=RUN and hazard, branch_taken and mem_access are all 0, including during reset.
- mem_stall = mem_access & ~mem_ready. It is valid in RUN and MEM_WAIT, and takes effect in the same cycle (zero latency).
- Priority, evaluated every cycle:
  - 1. ERR: freeze_if/id/exe/mem=1, bubble_wb=1, flushes=0.
  - 2. mem_stall: freeze_if/id/exe/mem=1, bubble_wb=1. Flushes are suppressed, and any branch_taken is held in frozen EXE and serviced later.
  - 3. branch_taken: flush_id=1, flush_exe=1, no freeze. A hazard in the same cycle is ignored because the ID instruction is squashed.
  - 4. hazard: freeze_if=1, freeze_id=1, flush_exe=1.
  - 5. Otherwise all outputs are 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt <= 1.
  - MEM_WAIT stays while mem_stall; wait_cnt increments, saturating at all-ones.
  - MEM_WAIT -> RUN when mem_ready (or mem_access drops); wait_cnt <= 0. Pipeline advances that same cycle under rules 3-5.
  - MEM_WAIT -> ERR when MEM_TIMEOUT!=0, mem_stall=1 and wait_cnt==MEM_TIMEOUT. The error is asserted on the next cycle.
  - ERR is terminal; mem_timeout_err=1 until reset.
- A memory access with mem_ready=1 in its first cycle never enters MEM_WAIT.
- Back-to-back accesses: RUN/MEM_WAIT re-entered per access; wait_cnt restarts at 1.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN next edge with all registers cleared.

Optional Feature:
- Macro PIPELINE_CTRL_PERF_CNT_EN.
- Defined: three CNT_W saturating counters.
  - stall_cycles +1 per cycle where rule 4 is active.
  - flush_count +1 per cycle where rule 3 is active.
  - mem_wait_cycles +1 per cycle where rule 2 is active.
  - perf_clr zeroes all three and overrides any same-cycle increment.
  - Counters hold at 2^CNT_W-1.
- Undefined: counter logic is absent and all three ports are tied to 0.

Test Plan:
- Reset with rst_n=0 for 2 cycles, all inputs 1 -> after release with inputs 0: state=0, all controls 0, err=0, counters 0.
- hazard=1 for 1 cycle in RUN -> same cycle freeze_if=freeze_id=flush_exe=1, freeze_exe=0; stall_cycles=1.
- branch_taken=1 and hazard=1 together -> flush_id=flush_exe=1, freeze_if=0; flush_count=1, stall_cycles unchanged.
- mem_access=1 with mem_ready low 3 cycles then high -> freezes and bubble_wb high 3 cycles, state=1 for cycles 2-3, state=0 after the ready cycle; mem_wait_cycles=3.
- mem_stall overlapping branch_taken=1 for 2 cycles then mem_ready -> no flush during stall; flush_id/flush_exe=1 on the ready cycle.
- MEM_TIMEOUT=4, mem_access=1, mem_ready=0 held -> state=2 and mem_timeout_err=1 on the 5th wait cycle; remains set until rst_n=0.
